// File: rtl/alu_writeback.sv
// Writeback stage behind the ALU: registers result/flags, updates the two-entry operand file,
// tracks branch outcome, sticky overflow and retire count. Optional macro: ALU_WB_TRAP_EN.
module alu_writeback #(
    parameter logic [31:0] RESET_A = 32'h0000_0000,
    parameter logic [31:0] RESET_B = 32'h0000_0000,
    parameter int          COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instruction,
    input  logic [31:0]        in_result,
    input  logic [2:0]         in_flags,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_result,
    output logic [2:0]         out_flags,
    output logic               out_we,
    output logic               out_dest,
    output logic               branch_taken,
    output logic [15:0]        branch_offset,
    output logic [31:0]        reg_A,
    output logic [31:0]        reg_B,
    output logic               sticky_ovf,
    input  logic               ovf_clr,
    input  logic               trap_ack,
    output logic [COUNT_W-1:0] retire_count
);

    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_TRAP = 2'd2} state_t;

`ifdef ALU_WB_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    state_t               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [31:0]          out_result_q, out_result_d;
    logic [2:0]           out_flags_q, out_flags_d;
    logic                 out_we_q, out_we_d;
    logic                 out_dest_q, out_dest_d;
    logic                 branch_taken_q, branch_taken_d;
    logic [15:0]          branch_offset_q, branch_offset_d;
    logic [31:0]          reg_a_q, reg_a_d;
    logic [31:0]          reg_b_q, reg_b_d;
    logic                 sticky_ovf_q, sticky_ovf_d;
    logic [COUNT_W-1:0]   retire_count_q, retire_count_d;

    logic [5:0]           opcode_s, func_s;
    logic [4:0]           dest_idx_s;
    logic                 wr_op_s, trap_op_s, ovf_s, is_branch_s, we_s;
    logic                 in_ready_s, accept_s, retire_s;
    logic                 unused_s;

    assign opcode_s = in_instruction[31:26];
    assign func_s   = in_instruction[5:0];
    assign unused_s = ^{trap_ack, in_instruction[25:21], in_instruction[10:6]};

    // Instruction decode: destination index, write candidacy, trapping and branch class.
    always_comb begin
        dest_idx_s  = 5'd0;
        wr_op_s     = 1'b0;
        is_branch_s = 1'b0;
        case (opcode_s)
            6'h00: begin
                dest_idx_s = in_instruction[15:11];
                case (func_s)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h00, 6'h04, 6'h02, 6'h06,
                    6'h03, 6'h07, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: wr_op_s = 1'b1;
                    default: wr_op_s = 1'b0;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                dest_idx_s = in_instruction[20:16];
                wr_op_s    = 1'b1;
            end
            6'h04, 6'h05: is_branch_s = 1'b1;
            default: wr_op_s = 1'b0;
        endcase
        trap_op_s = ((opcode_s == 6'h00) && ((func_s == 6'h20) || (func_s == 6'h22)))
                    || (opcode_s == 6'h08);
        ovf_s     = trap_op_s && in_flags[2];
        we_s      = wr_op_s && (dest_idx_s[4:1] == 4'd0) && !ovf_s;
    end

    // Handshake, next-state and next-value computation for every register in the stage.
    always_comb begin
        in_ready_s = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_ready);
        accept_s   = in_valid && in_ready_s;
`ifdef ALU_WB_TRAP_EN
        retire_s   = ((state_q == ST_FULL) && out_ready) || ((state_q == ST_TRAP) && trap_ack);
`else
        retire_s   = (state_q == ST_FULL) && out_ready;
`endif
        state_d         = state_q;
        out_result_d    = out_result_q;
        out_flags_d     = out_flags_q;
        out_we_d        = out_we_q;
        out_dest_d      = out_dest_q;
        branch_taken_d  = branch_taken_q;
        branch_offset_d = branch_offset_q;
        reg_a_d         = reg_a_q;
        reg_b_d         = reg_b_q;
        if (accept_s) begin
            state_d         = (TRAP_EN && ovf_s) ? ST_TRAP : ST_FULL;
            out_result_d    = in_result;
            out_flags_d     = in_flags;
            out_we_d        = we_s;
            out_dest_d      = we_s ? dest_idx_s[0] : 1'b0;
            branch_taken_d  = is_branch_s && (in_result != 32'd0);
            branch_offset_d = is_branch_s ? in_result[15:0] : 16'd0;
            if (we_s && !dest_idx_s[0]) begin
                reg_a_d = in_result;
            end else if (we_s && dest_idx_s[0]) begin
                reg_b_d = in_result;
            end else begin
                reg_a_d = reg_a_q;
            end
        end else if (retire_s) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_q;
        end
        // A new overflow outranks a simultaneous clear request.
        if (accept_s && ovf_s) begin
            sticky_ovf_d = 1'b1;
        end else if (ovf_clr) begin
            sticky_ovf_d = 1'b0;
        end else begin
            sticky_ovf_d = sticky_ovf_q;
        end
        retire_count_d = retire_s ? (retire_count_q + {{(COUNT_W-1){1'b0}}, 1'b1}) : retire_count_q;
        out_valid_d    = (state_d != ST_EMPTY);
    end

    // Stage state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_EMPTY;
            out_valid_q     <= 1'b0;
            out_result_q    <= 32'd0;
            out_flags_q     <= 3'd0;
            out_we_q        <= 1'b0;
            out_dest_q      <= 1'b0;
            branch_taken_q  <= 1'b0;
            branch_offset_q <= 16'd0;
            reg_a_q         <= RESET_A;
            reg_b_q         <= RESET_B;
            sticky_ovf_q    <= 1'b0;
            retire_count_q  <= {COUNT_W{1'b0}};
        end else begin
            state_q         <= state_d;
            out_valid_q     <= out_valid_d;
            out_result_q    <= out_result_d;
            out_flags_q     <= out_flags_d;
            out_we_q        <= out_we_d;
            out_dest_q      <= out_dest_d;
            branch_taken_q  <= branch_taken_d;
            branch_offset_q <= branch_offset_d;
            reg_a_q         <= reg_a_d;
            reg_b_q         <= reg_b_d;
            sticky_ovf_q    <= sticky_ovf_d;
            retire_count_q  <= retire_count_d;
        end
    end

    assign in_ready      = in_ready_s;
    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_flags     = out_flags_q;
    assign out_we        = out_we_q;
    assign out_dest      = out_dest_q;
    assign branch_taken  = branch_taken_q;
    assign branch_offset = branch_offset_q;
    assign reg_A         = reg_a_q;
    assign reg_B         = reg_b_q;
    assign sticky_ovf    = sticky_ovf_q;
    assign retire_count  = retire_count_q;

endmodule
